// File: rtl/pipeline_control_unit.sv
// Pipelined MIPS control unit: ID-stage decode, ID/EX, EX/MEM and MEM/WB
// control registers, load-use hazard detection, flush handling and a
// saturating illegal-opcode counter.
module pipeline_control_unit #(
    parameter int unsigned ALUOP_WIDTH    = 4,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned LINK_REG       = 31,
    parameter int unsigned HAZARD_EN      = 1,
    parameter int unsigned ILL_CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_id,
    input  logic [5:0]                op_id,
    input  logic [5:0]                funct_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs_id,
    input  logic [REG_ADDR_WIDTH-1:0] rt_id,
    input  logic [REG_ADDR_WIDTH-1:0] rd_id,
    input  logic                      flush,
    output logic                      jump_id,
    output logic                      jr_id,
    output logic                      stall,
    output logic                      pc_write_en,
    output logic                      ifid_write_en,
    output logic                      ex_alu_src,
    output logic                      ex_branch_eq,
    output logic                      ex_branch_ne,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_reg_write,
    output logic                      ex_mem_to_reg,
    output logic                      ex_jal,
    output logic [ALUOP_WIDTH-1:0]    ex_alu_op,
    output logic [REG_ADDR_WIDTH-1:0] ex_write_reg,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      mem_reg_write,
    output logic                      mem_mem_to_reg,
    output logic                      mem_jal,
    output logic [REG_ADDR_WIDTH-1:0] mem_write_reg,
    output logic                      wb_reg_write,
    output logic                      wb_mem_to_reg,
    output logic                      wb_jal,
    output logic [REG_ADDR_WIDTH-1:0] wb_write_reg,
    output logic [ILL_CNT_WIDTH-1:0]  illegal_cnt
);

    localparam logic [5:0] opRtype  = 6'h00;
    localparam logic [5:0] opJ      = 6'h02;
    localparam logic [5:0] opJal    = 6'h03;
    localparam logic [5:0] opBeq    = 6'h04;
    localparam logic [5:0] opBne    = 6'h05;
    localparam logic [5:0] opAddi   = 6'h08;
    localparam logic [5:0] opAndi   = 6'h0C;
    localparam logic [5:0] opOri    = 6'h0D;
    localparam logic [5:0] opLui    = 6'h0F;
    localparam logic [5:0] opLw     = 6'h23;
    localparam logic [5:0] opSw     = 6'h2B;
    localparam logic [5:0] functJr  = 6'h08;

    logic                      regDst;
    logic                      aluSrc;
    logic                      branchEq;
    logic                      branchNe;
    logic                      memRead;
    logic                      memWrite;
    logic                      regWrite;
    logic                      memToReg;
    logic                      jal;
    logic                      isJump;
    logic                      isJr;
    logic                      illegal;
    logic                      rtIsSrc;
    logic [3:0]                aluCode;
    logic [ALUOP_WIDTH-1:0]    aluOpId;
    logic [REG_ADDR_WIDTH-1:0] writeRegId;
    logic                      regWriteId;
    logic                      hazard;
    logic                      hazardEn;
    logic                      loadBubble;
    logic                      rsMatch;
    logic                      rtMatch;

    // Opcode/funct decode into the raw control set for the ID instruction.
    always_comb begin
        regDst   = 1'b0;
        aluSrc   = 1'b0;
        branchEq = 1'b0;
        branchNe = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        memToReg = 1'b0;
        jal      = 1'b0;
        isJump   = 1'b0;
        isJr     = 1'b0;
        illegal  = 1'b0;
        rtIsSrc  = 1'b0;
        aluCode  = 4'b0000;
        case (op_id)
            opRtype: begin
                rtIsSrc = 1'b1;
                if (funct_id == functJr) begin
                    isJr = 1'b1;
                end else begin
                    regDst   = 1'b1;
                    regWrite = 1'b1;
                    aluCode  = 4'b0111;
                end
            end
            opAddi: begin aluSrc = 1'b1; regWrite = 1'b1; aluCode = 4'b0100; end
            opOri:  begin aluSrc = 1'b1; regWrite = 1'b1; aluCode = 4'b0101; end
            opAndi: begin aluSrc = 1'b1; regWrite = 1'b1; aluCode = 4'b0110; end
            opLui:  begin aluSrc = 1'b1; regWrite = 1'b1; aluCode = 4'b1000; end
            opBeq:  begin branchEq = 1'b1; rtIsSrc = 1'b1; aluCode = 4'b0001; end
            opBne:  begin branchNe = 1'b1; rtIsSrc = 1'b1; aluCode = 4'b0001; end
            opLw: begin
                aluSrc   = 1'b1;
                memToReg = 1'b1;
                regWrite = 1'b1;
                memRead  = 1'b1;
                aluCode  = 4'b0010;
            end
            opSw: begin
                aluSrc   = 1'b1;
                memWrite = 1'b1;
                rtIsSrc  = 1'b1;
                aluCode  = 4'b0011;
            end
            opJ:    isJump = 1'b1;
            opJal:  begin isJump = 1'b1; regWrite = 1'b1; jal = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

    assign aluOpId    = ALUOP_WIDTH'(aluCode);
    assign writeRegId = jal ? REG_ADDR_WIDTH'(LINK_REG) : (regDst ? rd_id : rt_id);
    // Writes to register 0 are architecturally discarded; drop them here.
    assign regWriteId = regWrite & (writeRegId != '0);

    assign jump_id = valid_id & isJump;
    assign jr_id   = valid_id & isJr;

    // Load-use hazard: the load in EX produces a register the ID instruction reads.
    assign hazardEn = (HAZARD_EN != 0);
    assign rsMatch  = (ex_write_reg == rs_id);
    assign rtMatch  = (ex_write_reg == rt_id) & rtIsSrc;
    assign hazard   = hazardEn & valid_id & ex_mem_read & (ex_write_reg != '0)
                    & (rsMatch | rtMatch);
    assign stall         = hazard & ~flush;
    assign pc_write_en   = ~stall;
    assign ifid_write_en = ~stall;

    assign loadBubble = ~valid_id | flush | stall;

    // ID/EX register: bundle from decode, or an all-zero bubble.
    always_ff @(posedge clk) begin
        if (reset || loadBubble) begin
            ex_alu_src    <= 1'b0;
            ex_branch_eq  <= 1'b0;
            ex_branch_ne  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_jal        <= 1'b0;
            ex_alu_op     <= '0;
            ex_write_reg  <= '0;
        end else begin
            ex_alu_src    <= aluSrc;
            ex_branch_eq  <= branchEq;
            ex_branch_ne  <= branchNe;
            ex_mem_read   <= memRead;
            ex_mem_write  <= memWrite;
            ex_reg_write  <= regWriteId;
            ex_mem_to_reg <= memToReg;
            ex_jal        <= jal;
            ex_alu_op     <= aluOpId;
            ex_write_reg  <= writeRegId;
        end
    end

    // EX/MEM register: always advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_jal        <= 1'b0;
            mem_write_reg  <= '0;
        end else begin
            mem_read       <= ex_mem_read;
            mem_write      <= ex_mem_write;
            mem_reg_write  <= ex_reg_write;
            mem_mem_to_reg <= ex_mem_to_reg;
            mem_jal        <= ex_jal;
            mem_write_reg  <= ex_write_reg;
        end
    end

    // MEM/WB register: always advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_jal        <= 1'b0;
            wb_write_reg  <= '0;
        end else begin
            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_mem_to_reg;
            wb_jal        <= mem_jal;
            wb_write_reg  <= mem_write_reg;
        end
    end

    // Saturating count of illegal opcodes actually accepted into EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt <= '0;
        end else if (illegal && !loadBubble && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + ILL_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit. A second instance with a wider
// ALU op field and hazard detection disabled shares the same stimulus.
module tb_pipeline_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_id;
    logic [5:0] op_id;
    logic [5:0] funct_id;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic [4:0] rd_id;
    logic       flush;

    logic       jump_id, jr_id, stall, pc_write_en, ifid_write_en;
    logic       ex_alu_src, ex_branch_eq, ex_branch_ne, ex_mem_read, ex_mem_write;
    logic       ex_reg_write, ex_mem_to_reg, ex_jal;
    logic [3:0] ex_alu_op;
    logic [4:0] ex_write_reg;
    logic       mem_read, mem_write, mem_reg_write, mem_mem_to_reg, mem_jal;
    logic [4:0] mem_write_reg;
    logic       wb_reg_write, wb_mem_to_reg, wb_jal;
    logic [4:0] wb_write_reg;
    logic [7:0] illegal_cnt;

    logic       jumpB, jrB, stallB, pcWeB, ifidWeB;
    logic       exAluSrcB, exBeqB, exBneB, exMemReadB, exMemWriteB;
    logic       exRegWriteB, exMemToRegB, exJalB;
    logic [5:0] exAluOpB;
    logic [4:0] exWriteRegB;
    logic       memReadB, memWriteB, memRegWriteB, memMemToRegB, memJalB;
    logic [4:0] memWriteRegB;
    logic       wbRegWriteB, wbMemToRegB, wbJalB;
    logic [4:0] wbWriteRegB;
    logic [7:0] illegalCntB;

    logic [11:0] exCtl;
    logic [16:0] exAll;
    logic [9:0]  memAll;
    logic [7:0]  wbAll;

    int compared   = 0;
    int mismatched = 0;

    assign exCtl  = {ex_alu_src, ex_branch_eq, ex_branch_ne, ex_mem_read, ex_mem_write,
                     ex_reg_write, ex_mem_to_reg, ex_jal, ex_alu_op};
    assign exAll  = {exCtl, ex_write_reg};
    assign memAll = {mem_read, mem_write, mem_reg_write, mem_mem_to_reg, mem_jal,
                     mem_write_reg};
    assign wbAll  = {wb_reg_write, wb_mem_to_reg, wb_jal, wb_write_reg};

    always #5 clk = ~clk;

    pipeline_control_unit dut (
        .clk(clk), .reset(reset), .valid_id(valid_id), .op_id(op_id),
        .funct_id(funct_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .flush(flush),
        .jump_id(jump_id), .jr_id(jr_id), .stall(stall), .pc_write_en(pc_write_en),
        .ifid_write_en(ifid_write_en), .ex_alu_src(ex_alu_src),
        .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_jal(ex_jal),
        .ex_alu_op(ex_alu_op), .ex_write_reg(ex_write_reg), .mem_read(mem_read),
        .mem_write(mem_write), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_jal(mem_jal),
        .mem_write_reg(mem_write_reg), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_jal(wb_jal), .wb_write_reg(wb_write_reg),
        .illegal_cnt(illegal_cnt)
    );

    pipeline_control_unit #(
        .ALUOP_WIDTH(6),
        .HAZARD_EN(0)
    ) dutB (
        .clk(clk), .reset(reset), .valid_id(valid_id), .op_id(op_id),
        .funct_id(funct_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .flush(flush),
        .jump_id(jumpB), .jr_id(jrB), .stall(stallB), .pc_write_en(pcWeB),
        .ifid_write_en(ifidWeB), .ex_alu_src(exAluSrcB), .ex_branch_eq(exBeqB),
        .ex_branch_ne(exBneB), .ex_mem_read(exMemReadB), .ex_mem_write(exMemWriteB),
        .ex_reg_write(exRegWriteB), .ex_mem_to_reg(exMemToRegB), .ex_jal(exJalB),
        .ex_alu_op(exAluOpB), .ex_write_reg(exWriteRegB), .mem_read(memReadB),
        .mem_write(memWriteB), .mem_reg_write(memRegWriteB),
        .mem_mem_to_reg(memMemToRegB), .mem_jal(memJalB), .mem_write_reg(memWriteRegB),
        .wb_reg_write(wbRegWriteB), .wb_mem_to_reg(wbMemToRegB), .wb_jal(wbJalB),
        .wb_write_reg(wbWriteRegB), .illegal_cnt(illegalCntB)
    );

    // Drive the ID inputs and let the combinational outputs settle.
    task automatic setId(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic fl);
        valid_id = v;
        op_id    = op;
        funct_id = fn;
        rs_id    = rs;
        rt_id    = rt;
        rd_id    = rd;
        flush    = fl;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble;
        setId(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bubble();
        tick();
        tick();
        reset = 1'b0;
        #1;
        compared++;
        if (exAll !== 17'h0) begin
            $display("FAIL reset_ex: got %h expected %h", exAll, 17'h0); mismatched++;
        end
        compared++;
        if (memAll !== 10'h0) begin
            $display("FAIL reset_mem: got %h expected %h", memAll, 10'h0); mismatched++;
        end
        compared++;
        if (wbAll !== 8'h0) begin
            $display("FAIL reset_wb: got %h expected %h", wbAll, 8'h0); mismatched++;
        end
        compared++;
        if (illegal_cnt !== 8'd0) begin
            $display("FAIL reset_cnt: got %0d expected 0", illegal_cnt); mismatched++;
        end
        compared++;
        if ({stall, pc_write_en, ifid_write_en} !== 3'b011) begin
            $display("FAIL reset_stall: got %b expected 011",
                     {stall, pc_write_en, ifid_write_en}); mismatched++;
        end
    endtask

    task automatic test_lw_latency;
        setId(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        bubble();
        compared++;
        if (exAll !== {12'b1_0_0_1_0_1_1_0_0010, 5'd8}) begin
            $display("FAIL lw_ex: got %h expected %h", exAll,
                     {12'b1_0_0_1_0_1_1_0_0010, 5'd8}); mismatched++;
        end
        tick();
        compared++;
        if (memAll !== {5'b1_0_1_1_0, 5'd8}) begin
            $display("FAIL lw_mem: got %h expected %h", memAll, {5'b1_0_1_1_0, 5'd8});
            mismatched++;
        end
        compared++;
        if (ex_mem_read !== 1'b0) begin
            $display("FAIL lw_ex_cleared: got %b expected 0", ex_mem_read); mismatched++;
        end
        tick();
        compared++;
        if (wbAll !== {3'b1_1_0, 5'd8}) begin
            $display("FAIL lw_wb: got %h expected %h", wbAll, {3'b1_1_0, 5'd8});
            mismatched++;
        end
        compared++;
        if (mem_read !== 1'b0) begin
            $display("FAIL lw_mem_cleared: got %b expected 0", mem_read); mismatched++;
        end
    endtask

    task automatic test_load_use;
        // LW r8 then ADD r10 = r8 + r9.
        setId(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        setId(1'b1, 6'h00, 6'h20, 5'd8, 5'd9, 5'd10, 1'b0);
        compared++;
        if ({stall, pc_write_en, ifid_write_en} !== 3'b100) begin
            $display("FAIL lu_stall: got %b expected 100",
                     {stall, pc_write_en, ifid_write_en}); mismatched++;
        end
        compared++;
        if ({stallB, pcWeB} !== 2'b01) begin
            $display("FAIL lu_hazard_disabled: got %b expected 01", {stallB, pcWeB});
            mismatched++;
        end
        tick();
        compared++;
        if (exAll !== 17'h0) begin
            $display("FAIL lu_bubble: got %h expected %h", exAll, 17'h0); mismatched++;
        end
        compared++;
        if ({stall, mem_read} !== 2'b01) begin
            $display("FAIL lu_stall_one_cycle: got %b expected 01", {stall, mem_read});
            mismatched++;
        end
        tick();
        bubble();
        compared++;
        if (exAll !== {12'b0_0_0_0_0_1_0_0_0111, 5'd10}) begin
            $display("FAIL lu_add_ex: got %h expected %h", exAll,
                     {12'b0_0_0_0_0_1_0_0_0111, 5'd10}); mismatched++;
        end
        // ADDI only reads rs, so rt == 8 is no hazard.
        setId(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        setId(1'b1, 6'h08, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        compared++;
        if (stall !== 1'b0) begin
            $display("FAIL lu_addi_nostall: got %b expected 0", stall); mismatched++;
        end
        tick();
        bubble();
        compared++;
        if (exAll !== {12'b1_0_0_0_0_1_0_0_0100, 5'd8}) begin
            $display("FAIL lu_addi_ex: got %h expected %h", exAll,
                     {12'b1_0_0_0_0_1_0_0_0100, 5'd8}); mismatched++;
        end
        // SW reads rt, so rt == 8 stalls.
        setId(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        setId(1'b1, 6'h2B, 6'h00, 5'd2, 5'd8, 5'd0, 1'b0);
        compared++;
        if (stall !== 1'b1) begin
            $display("FAIL lu_sw_rt_stall: got %b expected 1", stall); mismatched++;
        end
        bubble();
        tick();
        // Load to r0 never creates a hazard.
        setId(1'b1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        setId(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd3, 1'b0);
        compared++;
        if ({stall, ex_mem_read, ex_reg_write} !== 3'b010) begin
            $display("FAIL lu_r0_nostall: got %b expected 010",
                     {stall, ex_mem_read, ex_reg_write}); mismatched++;
        end
        bubble();
        tick();
        tick();
    endtask

    task automatic test_flush;
        setId(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        setId(1'b1, 6'h00, 6'h20, 5'd8, 5'd9, 5'd10, 1'b1);
        compared++;
        if ({stall, pc_write_en} !== 2'b01) begin
            $display("FAIL flush_stall: got %b expected 01", {stall, pc_write_en});
            mismatched++;
        end
        tick();
        compared++;
        if (exAll !== 17'h0) begin
            $display("FAIL flush_ex: got %h expected %h", exAll, 17'h0); mismatched++;
        end
        // A stalled illegal opcode is not counted.
        setId(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        setId(1'b1, 6'h3F, 6'h00, 5'd8, 5'd0, 5'd0, 1'b0);
        compared++;
        if (stall !== 1'b1) begin
            $display("FAIL flush_ill_stall: got %b expected 1", stall); mismatched++;
        end
        tick();
        bubble();
        compared++;
        if (illegal_cnt !== 8'd0) begin
            $display("FAIL stalled_ill_cnt: got %0d expected 0", illegal_cnt); mismatched++;
        end
        // A flushed illegal opcode is not counted.
        setId(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        bubble();
        compared++;
        if (illegal_cnt !== 8'd0) begin
            $display("FAIL flushed_ill_cnt: got %0d expected 0", illegal_cnt); mismatched++;
        end
        tick();
        tick();
    endtask

    task automatic test_jal_jr;
        setId(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        compared++;
        if ({jump_id, jr_id} !== 2'b10) begin
            $display("FAIL jal_jump_id: got %b expected 10", {jump_id, jr_id}); mismatched++;
        end
        tick();
        bubble();
        compared++;
        if ({ex_jal, ex_reg_write, ex_write_reg} !== {2'b11, 5'd31}) begin
            $display("FAIL jal_ex: got %h expected %h",
                     {ex_jal, ex_reg_write, ex_write_reg}, {2'b11, 5'd31}); mismatched++;
        end
        tick();
        tick();
        compared++;
        if (wbAll !== {3'b1_0_1, 5'd31}) begin
            $display("FAIL jal_wb: got %h expected %h", wbAll, {3'b1_0_1, 5'd31});
            mismatched++;
        end
        // Jump without valid_id is a bubble.
        setId(1'b0, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        compared++;
        if (jump_id !== 1'b0) begin
            $display("FAIL j_invalid: got %b expected 0", jump_id); mismatched++;
        end
        setId(1'b1, 6'h00, 6'h08, 5'd5, 5'd0, 5'd0, 1'b0);
        compared++;
        if ({jump_id, jr_id} !== 2'b01) begin
            $display("FAIL jr_id: got %b expected 01", {jump_id, jr_id}); mismatched++;
        end
        tick();
        compared++;
        if (exAll !== 17'h0) begin
            $display("FAIL jr_ex: got %h expected %h", exAll, 17'h0); mismatched++;
        end
        // R-type targeting r0 loses its write enable.
        setId(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        bubble();
        compared++;
        if (exAll !== {12'b0_0_0_0_0_0_0_0_0111, 5'd0}) begin
            $display("FAIL rd0_ex: got %h expected %h", exAll,
                     {12'b0_0_0_0_0_0_0_0_0111, 5'd0}); mismatched++;
        end
    endtask

    task automatic test_ori_wide;
        setId(1'b1, 6'h0D, 6'h00, 5'd1, 5'd3, 5'd0, 1'b0);
        tick();
        bubble();
        compared++;
        if ({ex_alu_op, ex_write_reg} !== {4'b0101, 5'd3}) begin
            $display("FAIL ori_ex: got %h expected %h", {ex_alu_op, ex_write_reg},
                     {4'b0101, 5'd3}); mismatched++;
        end
        compared++;
        if (exAluOpB !== 6'b000101) begin
            $display("FAIL ori_wide_aluop: got %b expected 000101", exAluOpB); mismatched++;
        end
    endtask

    task automatic test_illegal_sat;
        setId(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 10 || i == 255) begin
                compared++;
                if (illegal_cnt !== 8'(i)) begin
                    $display("FAIL ill_cnt_%0d: got %0d expected %0d", i, illegal_cnt, i);
                    mismatched++;
                end
            end
        end
        compared++;
        if (illegal_cnt !== 8'd255) begin
            $display("FAIL ill_cnt_sat: got %0d expected 255", illegal_cnt); mismatched++;
        end
        compared++;
        if ({exAll, jump_id, jr_id, stall} !== 20'h0) begin
            $display("FAIL ill_controls: got %h expected %h",
                     {exAll, jump_id, jr_id, stall}, 20'h0); mismatched++;
        end
    endtask

    task automatic test_reset_mid;
        setId(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        setId(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        compared++;
        if ({mem_read, ex_jal} !== 2'b11) begin
            $display("FAIL mid_inflight: got %b expected 11", {mem_read, ex_jal});
            mismatched++;
        end
        setId(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        reset = 1'b1;
        tick();
        compared++;
        if ({exAll, memAll, wbAll} !== 35'h0) begin
            $display("FAIL mid_reset_stages: got %h expected %h",
                     {exAll, memAll, wbAll}, 35'h0); mismatched++;
        end
        compared++;
        if ({illegal_cnt, stall} !== 9'h0) begin
            $display("FAIL mid_reset_cnt: got %h expected %h", {illegal_cnt, stall}, 9'h0);
            mismatched++;
        end
        reset = 1'b0;
        bubble();
    endtask

    initial begin
        reset = 1'b1;
        bubble();
        test_reset();
        test_lw_latency();
        test_load_use();
        test_flush();
        test_jal_jr();
        test_ori_wide();
        test_illegal_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
